// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill
//  Description : AXI4 read-master refill engine for the instruction cache
//                data array. It takes one cacheable miss, issues a single
//                INCR burst for the aligned line, assembles the returned
//                beats and strobes the line into the data/tag arrays.
//                The pipeline stall is held for the whole miss window.
//                Optional performance counters: ICACHE_REFILL_PERF_EN.
//                LINE_W must match the cache's CACHELINE_WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill #(
    parameter int LINE_W   = 64,
    parameter int AXI_DW   = 64,
    parameter int AXI_IDW  = 4,
    parameter int ARID_VAL = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss,
    input  logic [63:0]        miss_addr,
    output logic               stall_req,
    output logic               refresh,
    output logic [LINE_W-1:0]  cacheline_new,
    output logic [63:0]        refill_addr,
    output logic               refill_err,
    output logic               axi_arvalid,
    input  logic               axi_arready,
    output logic [63:0]        axi_araddr,
    output logic [7:0]         axi_arlen,
    output logic [2:0]         axi_arsize,
    output logic [1:0]         axi_arburst,
    output logic [AXI_IDW-1:0] axi_arid,
    input  logic               axi_rvalid,
    output logic               axi_rready,
    input  logic [AXI_DW-1:0]  axi_rdata,
    input  logic [1:0]         axi_rresp,
    input  logic               axi_rlast
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]        perf_miss_cnt,
    output logic [31:0]        perf_stall_cyc
`endif
);

    localparam int BEATS  = LINE_W / AXI_DW;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Byte-offset bits within a line; cleared to form the burst address.
    localparam logic [63:0]       c_OFF_MASK  = 64'(LINE_W / 8 - 1);
    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [7:0]        c_ARLEN     = 8'(BEATS - 1);
    localparam logic [2:0]        c_ARSIZE    = 3'($clog2(AXI_DW / 8));
    localparam logic [1:0]        c_BURST_INC = 2'b01;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_AR   = 2'd1;
    localparam logic [1:0] c_ST_R    = 2'd2;
    localparam logic [1:0] c_ST_FILL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = c_ST_IDLE,
        S_AR   = c_ST_AR,
        S_R    = c_ST_R,
        S_FILL = c_ST_FILL
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic                w_beat;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_err;
    logic [63:0]         r_refill_addr;
    logic [LINE_W-1:0]   r_line;

    // State register; reset drops any refill in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_beat       = 1'b0;
        stall_req    = 1'b0;
        axi_arvalid  = 1'b0;
        axi_rready   = 1'b0;
        refresh      = 1'b0;
        refill_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (miss) begin
                    w_accept     = 1'b1;
                    w_next_state = S_AR;
                end
            end
            S_AR: begin
                stall_req   = 1'b1;
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    w_next_state = S_R;
                end
            end
            S_R: begin
                stall_req  = 1'b1;
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    w_beat = 1'b1;
                    // Either a short burst or a full line ends collection.
                    if (axi_rlast || (r_beat_cnt == c_LAST_BEAT)) begin
                        w_next_state = S_FILL;
                    end
                end
            end
            S_FILL: begin
                stall_req    = 1'b1;
                refresh      = ~r_err;
                refill_err   = r_err;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Refill context: aligned address, beat counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refill_addr <= '0;
            r_beat_cnt    <= '0;
            r_err         <= 1'b0;
        end else if (w_accept) begin
            r_refill_addr <= miss_addr & ~c_OFF_MASK;
            r_beat_cnt    <= '0;
            r_err         <= 1'b0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            if (axi_rresp != 2'b00) begin
                r_err <= 1'b1;
            end
        end
    end

    // Line buffer: cleared on accept so a short burst leaves zeros behind.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_line <= '0;
        end else if (w_beat) begin
            for (int i = 0; i < BEATS; i++) begin
                if (r_beat_cnt == BEAT_W'(i)) begin
                    r_line[i*AXI_DW +: AXI_DW] <= axi_rdata;
                end
            end
        end
    end

    assign refill_addr   = r_refill_addr;
    assign cacheline_new = r_line;
    assign axi_araddr    = r_refill_addr;
    assign axi_arlen     = c_ARLEN;
    assign axi_arsize    = c_ARSIZE;
    assign axi_arburst   = c_BURST_INC;
    assign axi_arid      = AXI_IDW'(ARID_VAL);

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_stall;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_miss  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
            if (stall_req) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_miss_cnt  = r_perf_miss;
    assign perf_stall_cyc = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill
//  Description : Scoreboard bench for icache_refill. Instance u_dut uses the
//                default 64-bit bus (single beat); u_dut32 uses a 32-bit bus
//                (two beats per line). Expected lines are queued when a miss
//                is driven and compared when refresh/refill_err appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill;

    typedef struct {
        logic [63:0] line;
        logic        err;
        logic [63:0] addr;
    } exp_t;

    logic clk;
    logic rst;

    // Instance with 64-bit data bus
    logic        miss, refresh, stall_req, refill_err;
    logic [63:0] miss_addr, cacheline_new, refill_addr, araddr, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic [3:0]  arid;

    // Instance with 32-bit data bus
    logic        b_miss, b_refresh, b_stall_req, b_refill_err;
    logic [63:0] b_miss_addr, b_cacheline_new, b_refill_addr, b_araddr;
    logic [31:0] b_rdata;
    logic        b_arvalid, b_arready, b_rvalid, b_rready, b_rlast;
    logic [7:0]  b_arlen;
    logic [2:0]  b_arsize;
    logic [1:0]  b_arburst, b_rresp;
    logic [3:0]  b_arid;

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] perf_miss_cnt, perf_stall_cyc, b_perf_miss_cnt, b_perf_stall_cyc;
`endif

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ar_hs0   = 0;
    int   ar_hs1   = 0;

    icache_refill u_dut (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr),
        .stall_req(stall_req), .refresh(refresh), .cacheline_new(cacheline_new),
        .refill_addr(refill_addr), .refill_err(refill_err),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr),
        .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
        .axi_arid(arid), .axi_rvalid(rvalid), .axi_rready(rready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast)
`ifdef ICACHE_REFILL_PERF_EN
        , .perf_miss_cnt(perf_miss_cnt), .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    icache_refill #(.LINE_W(64), .AXI_DW(32), .AXI_IDW(4), .ARID_VAL(0)) u_dut32 (
        .clk(clk), .rst(rst), .miss(b_miss), .miss_addr(b_miss_addr),
        .stall_req(b_stall_req), .refresh(b_refresh), .cacheline_new(b_cacheline_new),
        .refill_addr(b_refill_addr), .refill_err(b_refill_err),
        .axi_arvalid(b_arvalid), .axi_arready(b_arready), .axi_araddr(b_araddr),
        .axi_arlen(b_arlen), .axi_arsize(b_arsize), .axi_arburst(b_arburst),
        .axi_arid(b_arid), .axi_rvalid(b_rvalid), .axi_rready(b_rready),
        .axi_rdata(b_rdata), .axi_rresp(b_rresp), .axi_rlast(b_rlast)
`ifdef ICACHE_REFILL_PERF_EN
        , .perf_miss_cnt(b_perf_miss_cnt), .perf_stall_cyc(b_perf_stall_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // AR handshake counters, sampled before the edge's updates land
    always @(posedge clk) begin
        if (!rst && arvalid && arready)     ar_hs0++;
        if (!rst && b_arvalid && b_arready) ar_hs1++;
    end

    // Scoreboard compare for the 64-bit instance
    always @(negedge clk) begin
        if (refresh || refill_err) begin
            if (sb0.size() == 0) begin
                check("sb0_unexpected", 64'(refresh | refill_err), 64'd0);
            end else begin
                e0 = sb0.pop_front();
                check("refresh", 64'(refresh), 64'(!e0.err));
                check("refill_err", 64'(refill_err), 64'(e0.err));
                check("refill_addr", refill_addr, e0.addr);
                check("stall_fill", 64'(stall_req), 64'd1);
                if (!e0.err) check("line", cacheline_new, e0.line);
            end
        end
    end

    // Scoreboard compare for the 32-bit instance
    always @(negedge clk) begin
        if (b_refresh || b_refill_err) begin
            if (sb1.size() == 0) begin
                check("sb1_unexpected", 64'(b_refresh | b_refill_err), 64'd0);
            end else begin
                e1 = sb1.pop_front();
                check("b_refresh", 64'(b_refresh), 64'(!e1.err));
                check("b_refill_addr", b_refill_addr, e1.addr);
                if (!e1.err) check("b_line", b_cacheline_new, e1.line);
            end
        end
    end

    // One refill on the 64-bit instance with optional AR/R stalls and a
    // stray miss while busy.
    task automatic refill0(input logic [63:0] addr, input logic [63:0] data,
                           input logic [1:0] resp, input int ar_wait,
                           input int r_wait, input bit busy_miss);
        logic [63:0] al;
        int          hs_start;
        al       = addr & ~64'h7;
        hs_start = ar_hs0;
        @(negedge clk);
        check("stall_idle", 64'(stall_req), 64'd0);
        miss      = 1'b1;
        miss_addr = addr;
        sb0.push_back('{line: data, err: (resp != 2'b00), addr: al});
        @(negedge clk);
        miss      = 1'b0;
        miss_addr = ~addr;
        check("stall_ar", 64'(stall_req), 64'd1);
        check("arvalid", 64'(arvalid), 64'd1);
        check("araddr", araddr, al);
        check("arlen", 64'(arlen), 64'd0);
        check("arsize", 64'(arsize), 64'd3);
        check("arburst", 64'(arburst), 64'd1);
        check("arid", 64'(arid), 64'd0);
        arready = 1'b0;
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk);
            check("ar_hold_valid", 64'(arvalid), 64'd1);
            check("ar_hold_addr", araddr, al);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("arvalid_drop", 64'(arvalid), 64'd0);
        check("rready", 64'(rready), 64'd1);
        if (busy_miss) begin
            miss      = 1'b1;
            miss_addr = addr + 64'h100;
        end
        for (int i = 0; i < r_wait; i++) begin
            @(negedge clk);
            miss = 1'b0;
        end
        miss   = 1'b0;
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        rlast  = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        check("fill_strobe", 64'(refresh | refill_err), 64'd1);
        @(negedge clk);
        check("stall_after", 64'(stall_req), 64'd0);
        check("refresh_after", 64'(refresh), 64'd0);
        check("err_after", 64'(refill_err), 64'd0);
        check("ar_handshakes", 64'(ar_hs0 - hs_start), 64'd1);
    endtask

    // One two-beat refill on the 32-bit instance; early_last ends after beat 0.
    task automatic refill1(input logic [63:0] addr, input logic [31:0] d0,
                           input logic [31:0] d1, input bit early_last,
                           input bit last1, input logic [63:0] exp_line);
        logic [63:0] al;
        al = addr & ~64'h7;
        @(negedge clk);
        b_miss      = 1'b1;
        b_miss_addr = addr;
        sb1.push_back('{line: exp_line, err: 1'b0, addr: al});
        @(negedge clk);
        b_miss = 1'b0;
        check("b_arvalid", 64'(b_arvalid), 64'd1);
        check("b_araddr", b_araddr, al);
        check("b_arlen", 64'(b_arlen), 64'd1);
        check("b_arsize", 64'(b_arsize), 64'd2);
        b_arready = 1'b1;
        @(negedge clk);
        b_arready = 1'b0;
        b_rvalid  = 1'b1;
        b_rdata   = d0;
        b_rlast   = early_last;
        @(negedge clk);
        b_rvalid = 1'b0;
        b_rlast  = 1'b0;
        if (early_last) begin
            // In FILL: a late beat must not be taken
            check("b_rready_fill", 64'(b_rready), 64'd0);
            b_rvalid = 1'b1;
            b_rdata  = d1;
            @(negedge clk);
            b_rvalid = 1'b0;
        end else begin
            check("b_rready_gap", 64'(b_rready), 64'd1);
            @(negedge clk);
            b_rvalid = 1'b1;
            b_rdata  = d1;
            b_rlast  = last1;
            @(negedge clk);
            b_rvalid = 1'b0;
            b_rlast  = 1'b0;
            check("b_fill", 64'(b_refresh), 64'd1);
            @(negedge clk);
        end
        check("b_stall_after", 64'(b_stall_req), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        miss = 1'b0; miss_addr = '0; arready = 1'b0; rvalid = 1'b0;
        rdata = '0; rresp = 2'b00; rlast = 1'b0;
        b_miss = 1'b0; b_miss_addr = '0; b_arready = 1'b0; b_rvalid = 1'b0;
        b_rdata = '0; b_rresp = 2'b00; b_rlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_refresh", 64'(refresh | refill_err), 64'd0);
        check("rst_addr", refill_addr, 64'd0);
        check("rst_line", cacheline_new, 64'd0);
        check("rst_b_line", b_cacheline_new, 64'd0);
        rst = 1'b0;

`ifdef ICACHE_REFILL_PERF_EN
        check("perf_miss_rst", 64'(perf_miss_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            refill0(64'h4000_0000 + 64'(i * 64), 64'hA5A5_0000_0000_0000 + 64'(i), 2'b00, 1, 0, 1'b0);
        end
        check("perf_miss_cnt", 64'(perf_miss_cnt), 64'd3);
        check("perf_stall_cyc", 64'(perf_stall_cyc), 64'd12);
`endif

        // Basic single-beat refill, no stalls
        refill0(64'h8000_0014, 64'h0013_0000_0093_0000, 2'b00, 0, 0, 1'b0);
        // AR backpressure
        refill0(64'h0000_1237, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 5, 2, 1'b0);
        // Error responses: line not installed
        refill0(64'h0000_2000, 64'h1111_2222_3333_4444, 2'b10, 0, 0, 1'b0);
        refill0(64'h0000_3008, 64'h5555_6666_7777_8888, 2'b11, 1, 1, 1'b0);
        // Clean refill after an error, with a stray miss during R
        refill0(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 2, 1'b1);

        // Reset while in AR
        @(negedge clk);
        miss = 1'b1; miss_addr = 64'h0000_5550;
        @(negedge clk);
        miss = 1'b0;
        check("pre_rst_arvalid", 64'(arvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_arvalid", 64'(arvalid), 64'd0);
        check("mid_rst_stall", 64'(stall_req), 64'd0);
        check("mid_rst_addr", refill_addr, 64'd0);
        refill0(64'h0000_6660, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 0, 0, 1'b0);

        // Two-beat lines on the 32-bit bus
        refill1(64'h8000_0014, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 64'h2222_2222_1111_1111);
        refill1(64'h0000_0100, 32'h3333_4444, 32'h5555_6666, 1'b0, 1'b0, 64'h5555_6666_3333_4444);
        refill1(64'h0000_0208, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1, 1'b0, 64'h0000_0000_AAAA_AAAA);
        refill1(64'h0000_030C, 32'h7777_8888, 32'h9999_0000, 1'b0, 1'b1, 64'h9999_0000_7777_8888);

        repeat (2) @(negedge clk);
        check("sb0_drained", 64'(sb0.size()), 64'd0);
        check("sb1_drained", 64'(sb1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- AXI4 read-master refill engine for the 2-way, 64-set instruction cache data array.
- Accepts a cacheable miss from the icache tag/control path and issues one burst read for the aligned cacheline.
- Assembles the returned beats and drives the data array's `refresh` / `cacheline_new` write port for exactly one cycle.
- Raises a pipeline stall request for the whole miss window.

Parameters:
- LINE_W, 64: cacheline width in bits. Must equal `CACHELINE_WIDTH.
- AXI_DW, 64: AXI read data width in bits. LINE_W must be an integer multiple of AXI_DW. BEATS = LINE_W/AXI_DW.
- AXI_IDW, 4: AXI ID width.
- ARID_VAL, 0: constant ARID driven on every request.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- miss  in  1  cacheable miss request; sampled only in IDLE
- miss_addr  in  64  fetch address of the miss
- stall_req  out  1  pipeline stall, high while a refill is in progress
- refresh  out  1  one-cycle write strobe to the data array and tag array
- cacheline_new  out  LINE_W  assembled line; valid while refresh=1
- refill_addr  out  64  line-aligned address of the current refill; valid from accept until return to IDLE
- refill_err  out  1  one-cycle pulse when a refill completed with an error response
- axi_arvalid  out  1  AR channel valid
- axi_arready  in  1  AR channel ready
- axi_araddr  out  64  AR channel address
- axi_arlen  out  8  AR burst length field
- axi_arsize  out  3  AR beat size field
- axi_arburst  out  2  AR burst type
- axi_arid  out  AXI_IDW  AR channel ID
- axi_rvalid  in  1  R channel valid
- axi_rready  out  1  R channel ready
- axi_rdata  in  AXI_DW  R channel data
- axi_rresp  in  2  R channel response
- axi_rlast  in  1  R channel last-beat flag

Behaviour:
- States: IDLE, AR, R, FILL.
- Reset values (rst=1 at a clk edge):
  - state=IDLE
  - all outputs 0: stall_req, refresh, refill_err, axi_arvalid, axi_rready, refill_addr, cacheline_new
  - beat_cnt=0, internal error flag=0
- IDLE:
  - On miss=1, latch refill_addr = miss_addr with its low log2(LINE_W/8) bits forced to 0.
  - Clear the line buffer and error flag, set beat_cnt=0, go to AR.
  - stall_req rises the cycle after miss is seen. The icache tag/control path holds the fetch until then.
- AR:
  - axi_arvalid=1, axi_araddr=refill_addr.
  - axi_arlen=BEATS-1, axi_arsize=log2(AXI_DW/8), axi_arburst=2'b01 (INCR), axi_arid=ARID_VAL.
  - AR payload is held stable while arvalid=1 and arready=0.
  - On arvalid & arready, go to R. arvalid drops the next cycle.
- R:
  - axi_rready=1.
  - Each rvalid cycle writes rdata into buffer slice [beat_cnt*AXI_DW +: AXI_DW] and increments beat_cnt.
  - rresp != 2'b00 on any beat sets the error flag.
  - Leave for FILL after the beat where rlast=1 OR beat_cnt==BEATS-1, whichever comes first.
  - An early rlast leaves the remaining slices 0. Beats arriving in later states are not accepted (rready=0).
- FILL:
  - One cycle only. stall_req stays high. cacheline_new shows the buffer.
  - Error flag clear: refresh=1, refill_err=0.
  - Error flag set: refresh=0, refill_err=1, so the line is not installed.
  - Next state is IDLE. stall_req drops the cycle after FILL.
- miss while not in IDLE is ignored; no queueing.
- Minimum miss-to-refresh latency: 3 cycles with arready and rvalid both immediate (BEATS=1).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The system reset also resets the interconnect, so no outstanding beats are drained.

Optional Feature:
- Macro: ICACHE_REFILL_PERF_EN.
- Defined:
  - Adds outputs perf_miss_cnt (32b) and perf_stall_cyc (32b), both reset to 0.
  - perf_miss_cnt increments on each accepted miss.
  - perf_stall_cyc increments every cycle stall_req=1.
  - Both wrap at 2^32 to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Basic hit path (defaults): miss=1, miss_addr=0x8000_0014.
  - Expect araddr=0x8000_0010, arlen=0, arsize=3, arburst=1.
  - rdata=0x0013_0000_0093_0000 → one-cycle refresh=1 with cacheline_new equal to that value, refill_addr=0x8000_0010, stall_req low after FILL.
- AR backpressure: arready low for 5 cycles → arvalid and araddr held stable throughout, exactly one handshake, refresh once.
- Multi-beat (AXI_DW=32, LINE_W=64): beats 0x1111_1111 then 0x2222_2222 with rlast on beat 2 → arlen=1, arsize=2, cacheline_new=0x2222_2222_1111_1111.
- Error response: rresp=2'b10 on the beat → refresh stays 0, refill_err pulses for one cycle, state returns to IDLE.
- Miss while busy, then reset: second miss during R is ignored (single AR); assert rst during AR → arvalid=0 and stall_req=0 next cycle; a new miss afterwards refills normally.
- With ICACHE_REFILL_PERF_EN defined: 3 refills with 4 stall cycles each → perf_miss_cnt=3, perf_stall_cyc=12.
